// File: rtl/module_secuenciador_spi.sv
// module_secuenciador_spi: sequences one SPI register-interface transfer per start/done handshake
// Loads up to MAX_BYTES TX bytes into the data register bank, writes the control word,
// polls the send bit until it clears, reads the RX bytes back and pulses done_o.
// Ports: clk_i/rst_i (sync active-high), start_i/len_i/tx_data_i request, busy_o/done_o/err_o/rx_data_o
// result, wr_o/reg_sel_o/addr_o/data_o register-write port, data_i register read data.
// Optional SPI_TIMEOUT_EN: abort polling after TIMEOUT_CYC cycles and flag err_o.
module module_secuenciador_spi #(
  parameter int MAX_BYTES = 8
`ifdef SPI_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [3:0]             len_i,
  input  logic [8*MAX_BYTES-1:0] tx_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [8*MAX_BYTES-1:0] rx_data_o,
  output logic                   wr_o,
  output logic                   reg_sel_o,
  output logic [3:0]             addr_o,
  output logic [31:0]            data_o,
  input  logic [31:0]            data_i
);
  localparam int W = 8*MAX_BYTES;
  localparam logic [3:0] LMAX = 4'(MAX_BYTES-1);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CTRL, POLL, RD_DATA, DONE} state_t;
  state_t state;
  logic [3:0] len, len_sat;
  logic [4:0] k;
  logic [1:0] pc;
  logic [W-1:0] tx_q, rx_buf;
  logic tmo;
  logic unused_bits;
  assign unused_bits = ^data_i[31:8];
  assign len_sat = (len_i > LMAX) ? LMAX : len_i;
  function automatic logic [31:0] ctrl_word(input logic [3:0] n, input logic send);
    return {12'd0, n, 8'd0, n, 3'b001, send};
  endfunction
`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk_i)
    tcnt <= (rst_i || state != POLL) ? '0 : tcnt + 1'b1;
  assign tmo = (state == POLL) && (tcnt == TW'(TIMEOUT_CYC-1));
`else
  assign tmo = 1'b0;
`endif
  // err_o is only ever set by tmo, so it stays constant 0 when the timeout is compiled out
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      rx_data_o <= '0;
      wr_o <= 1'b0;
      reg_sel_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
      len <= '0;
      k <= '0;
      pc <= '0;
      tx_q <= '0;
      rx_buf <= '0;
    end else begin
      wr_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state <= WR_DATA;
          busy_o <= 1'b1;
          err_o <= 1'b0;
          len <= len_sat;
          tx_q <= tx_data_i;
          rx_buf <= '0;
          k <= '0;
          wr_o <= 1'b1;
          reg_sel_o <= 1'b1;
          addr_o <= '0;
          data_o <= {24'h0, tx_data_i[7:0]};
        end
        WR_DATA: begin
          wr_o <= 1'b1;
          if (k[3:0] == len) begin
            state <= WR_CTRL;
            reg_sel_o <= 1'b0;
            data_o <= ctrl_word(len, 1'b1);
          end else begin
            k <= k + 5'd1;
            addr_o <= k[3:0] + 4'd1;
            data_o <= {24'h0, tx_q[{k[3:0] + 4'd1, 3'b000} +: 8]};
          end
        end
        WR_CTRL: begin
          pc <= '0;
          state <= err_o ? DONE : POLL;
          done_o <= err_o;
        end
        POLL: begin
          // the first two poll cycles give the interface time to register the send bit
          if (pc != 2'd2) pc <= pc + 2'd1;
          if (pc == 2'd2 && !data_i[0]) begin
            state <= RD_DATA;
            k <= '0;
            reg_sel_o <= 1'b1;
            addr_o <= '0;
          end else if (tmo) begin
            state <= WR_CTRL;
            wr_o <= 1'b1;
            data_o <= ctrl_word(len, 1'b0);
            err_o <= 1'b1;
          end
        end
        RD_DATA: begin
          if (k <= {1'b0, len}) rx_buf[{k[3:0], 3'b000} +: 8] <= data_i[7:0];
          if (k == {1'b0, len} + 5'd1) begin
            state <= DONE;
            done_o <= 1'b1;
            reg_sel_o <= 1'b0;
            rx_data_o <= rx_buf;
          end else begin
            k <= k + 5'd1;
            addr_o <= k[3:0] + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_module_secuenciador_spi.sv
// tb_module_secuenciador_spi: scoreboard bench for module_secuenciador_spi with an SPI register-interface model
module tb_module_secuenciador_spi;
  localparam int MB = 8;
  localparam int W = 8*MB;
  logic clk = 0, rst_i = 1, start_i = 0;
  logic [3:0] len_i = '0;
  logic [W-1:0] tx_data_i = '0;
  logic busy_o, done_o, err_o, wr_o, reg_sel_o;
  logic [W-1:0] rx_data_o;
  logic [3:0] addr_o;
  logic [31:0] data_o, data_i;
  typedef struct packed {logic sel; logic [3:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_wr[$];
  int n_cmp = 0, n_fail = 0;
  logic [7:0] rx_regs [16];
  int busy_cnt = 0, poll_busy = 2;
  bit stuck = 0;
  logic [W-1:0] last_rx = '0;

  module_secuenciador_spi #(.MAX_BYTES(MB)
`ifdef SPI_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .tx_data_i(tx_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rx_data_o(rx_data_o),
    .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
  );

  always #5 clk = ~clk;

  assign data_i = reg_sel_o ? {24'h0, rx_regs[addr_o]} : {31'h0, (stuck || busy_cnt != 0)};

  always @(posedge clk)
    if (wr_o === 1'b1 && reg_sel_o === 1'b0 && data_o[0] === 1'b1) busy_cnt <= poll_busy;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;

  always @(negedge clk)
    if (wr_o === 1'b1) begin
      wr_t e;
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got sel=%0b addr=%0d data=%h, expected no write", reg_sel_o, addr_o, data_o);
      end else begin
        e = exp_wr.pop_front();
        if (reg_sel_o !== e.sel || data_o !== e.data || (e.sel && addr_o !== e.addr)) begin
          n_fail++;
          $display("FAIL write: got sel=%0b addr=%0d data=%h, expected sel=%0b addr=%0d data=%h",
                   reg_sel_o, addr_o, data_o, e.sel, e.addr, e.data);
        end
      end
    end

  function automatic logic [31:0] ctrl(input logic [3:0] n, input bit send);
    return (32'(n) << 16) | (32'(n) << 4) | 32'h2 | 32'(send);
  endfunction

  function automatic logic [W-1:0] rx_exp(input int l);
    logic [W-1:0] r = '0;
    for (int i = 0; i <= l; i++) r[8*i +: 8] = rx_regs[i];
    return r;
  endfunction

  task automatic expect_txn(input int l, input logic [W-1:0] tx, input bit abort);
    for (int i = 0; i <= l; i++) exp_wr.push_back('{sel: 1'b1, addr: 4'(i), data: {24'h0, tx[8*i +: 8]}});
    exp_wr.push_back('{sel: 1'b0, addr: 4'h0, data: ctrl(4'(l), 1'b1)});
    if (abort) exp_wr.push_back('{sel: 1'b0, addr: 4'h0, data: ctrl(4'(l), 1'b0)});
  endtask

  task automatic start_txn(input logic [3:0] len_in, input logic [W-1:0] tx, input bit abort);
    expect_txn((len_in > 7) ? 7 : int'(len_in), tx, abort);
    start_i = 1; len_i = len_in; tx_data_i = tx;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc = 1; seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done_o === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_i = 1; start_i = 1; len_i = 4'h3; tx_data_i = '1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy_o, done_o, err_o, wr_o, reg_sel_o} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b, expected 00000", {busy_o, done_o, err_o, wr_o, reg_sel_o}); end
    n_cmp++; if (addr_o !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", addr_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", data_o); end
    n_cmp++; if (rx_data_o !== '0) begin n_fail++; $display("FAIL reset_rx: got %h, expected 0", rx_data_o); end
    rst_i = 0; start_i = 0;
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0 || wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_release: got busy=%b wr=%b, expected 0 0", busy_o, wr_o); end
  endtask

  task automatic test_single;
    int cyc; bit seen; logic [W-1:0] exp;
    rx_regs[0] = 8'h3C; poll_busy = 9;
    exp = rx_exp(0);
    start_txn(4'h0, 64'hA5, 0);
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL single_done: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 15) begin n_fail++; $display("FAIL single_latency: got %0d, expected 15", cyc); end
    n_cmp++; if (rx_data_o !== exp) begin n_fail++; $display("FAIL single_rx: got %h, expected %h", rx_data_o, exp); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, expected 0", err_o); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL single_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    last_rx = exp;
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b done=%b, expected 0 0", busy_o, done_o); end
  endtask

  task automatic test_full;
    int cyc; bit seen; logic [W-1:0] exp;
    for (int i = 0; i < 8; i++) rx_regs[i] = ~8'(i);
    poll_busy = 4;
    exp = rx_exp(7);
    start_txn(4'h7, 64'h0706050403020100, 0);
    repeat (3) @(posedge clk);
    #1;
    start_i = 1; len_i = 4'h0; tx_data_i = 64'hDEAD;
    @(posedge clk); #1;
    start_i = 0;
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b, expected 1", busy_o); end
    wait_done(cyc, seen);
    cyc += 4;
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL full_done: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 24) begin n_fail++; $display("FAIL full_latency: got %0d, expected 24", cyc); end
    n_cmp++; if (rx_data_o !== 64'hF8F9FAFBFCFDFEFF) begin n_fail++; $display("FAIL full_rx: got %h, expected %h", rx_data_o, 64'hF8F9FAFBFCFDFEFF); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL full_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    last_rx = exp;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_ignored_start: got busy=%b, expected 0", busy_o); end
  endtask

  task automatic test_saturate;
    int cyc; bit seen; logic [W-1:0] exp;
    for (int i = 0; i < 16; i++) rx_regs[i] = 8'h10 + 8'(i);
    poll_busy = 2;
    exp = rx_exp(7);
    start_txn(4'hF, 64'h1122334455667788, 0);
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL sat_done: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 22) begin n_fail++; $display("FAIL sat_latency: got %0d, expected 22", cyc); end
    n_cmp++; if (rx_data_o !== exp) begin n_fail++; $display("FAIL sat_rx: got %h, expected %h", rx_data_o, exp); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL sat_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    last_rx = exp;
  endtask

  task automatic test_back_to_back;
    int cyc; bit seen; logic [W-1:0] exp_a, exp_b;
    for (int i = 0; i < 16; i++) rx_regs[i] = 8'hC0 + 8'(i);
    poll_busy = 3;
    exp_a = rx_exp(2);
    exp_b = rx_exp(1);
    @(posedge clk); #1;
    start_txn(4'h2, 64'h00000000_00ABCDEF, 0);
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_done_a: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 13) begin n_fail++; $display("FAIL b2b_latency_a: got %0d, expected 13", cyc); end
    n_cmp++; if (rx_data_o !== exp_a) begin n_fail++; $display("FAIL b2b_rx_a: got %h, expected %h", rx_data_o, exp_a); end
    expect_txn(1, 64'h7E81, 0);
    start_i = 1; len_i = 4'h1; tx_data_i = 64'h7E81;
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done: got busy=%b, expected 0", busy_o); end
    @(posedge clk); #1;
    start_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || wr_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b wr=%b, expected 1 1", busy_o, wr_o); end
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_done_b: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 11) begin n_fail++; $display("FAIL b2b_latency_b: got %0d, expected 11", cyc); end
    n_cmp++; if (rx_data_o !== exp_b) begin n_fail++; $display("FAIL b2b_rx_b: got %h, expected %h", rx_data_o, exp_b); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL b2b_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    last_rx = exp_b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc; bit seen; logic [W-1:0] exp;
    poll_busy = 30;
    start_txn(4'h1, 64'h3344, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1;
    @(posedge clk); #1;
    n_cmp++; if (wr_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got wr=%b busy=%b done=%b, expected 0 0 0", wr_o, busy_o, done_o); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL midrst_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    rst_i = 0;
    @(posedge clk); #1;
    rx_regs[0] = 8'h99; poll_busy = 2;
    exp = rx_exp(0);
    start_txn(4'h0, 64'h42, 0);
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL midrst_done: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 8) begin n_fail++; $display("FAIL midrst_latency: got %0d, expected 8", cyc); end
    n_cmp++; if (rx_data_o !== exp) begin n_fail++; $display("FAIL midrst_rx: got %h, expected %h", rx_data_o, exp); end
    last_rx = exp;
    @(posedge clk); #1;
  endtask

`ifdef SPI_TIMEOUT_EN
  task automatic test_timeout;
    int cyc; bit seen;
    stuck = 1;
    start_txn(4'h0, 64'h5A, 1);
    wait_done(cyc, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL tmo_done: no done_o within bound, expected done"); end
    n_cmp++; if (cyc != 20) begin n_fail++; $display("FAIL tmo_latency: got %0d, expected 20", cyc); end
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b, expected 1", err_o); end
    n_cmp++; if (rx_data_o !== last_rx) begin n_fail++; $display("FAIL tmo_rx: got %h, expected %h", rx_data_o, last_rx); end
    n_cmp++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL tmo_writes: got %0d writes missing, expected 0", exp_wr.size()); end
    stuck = 0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rx_regs[i] = 8'h00;
    test_reset;
    test_single;
    test_full;
    test_saturate;
    test_back_to_back;
    test_reset_mid;
`ifdef SPI_TIMEOUT_EN
    test_timeout;
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
